// File: rtl/any1_mem_seq_if.sv
// Wishbone-classic bus between the load/store sequencer (master) and memory (slave).
// Carries one 64-bit data path with byte-lane selects and an 8-byte-aligned address.
interface any1_mem_seq_if #(
    parameter int AWID = 32
);
    logic            cyc_o;
    logic            stb_o;
    logic            we_o;
    logic [7:0]      sel_o;
    logic [AWID-1:0] adr_o;
    logic [63:0]     dat_o;
    logic            ack_i;
    logic            err_i;
    logic [63:0]     dat_i;

    modport master (
        output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        input  ack_i, err_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        output ack_i, err_i, dat_i
    );
endinterface

// File: rtl/any1_mem_seq.sv
// Load/store bus sequencer: splits accesses that cross an 8-byte boundary into two
// Wishbone cycles, merges and extends load data, and returns a one-cycle response.
module any1_mem_seq #(
    parameter int AWID = 32,
    parameter int TMO  = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_sext,
    input  logic [AWID-1:0] req_ea,
    input  logic [63:0]     req_dat,
    output logic            resp_valid,
    output logic [63:0]     resp_dat,
    output logic            resp_err,
    any1_mem_seq_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t          state, state_d;
    logic            we_r, sext_r, split_r, err_r;
    logic [1:0]      size_r;
    logic [2:0]      off_r;
    logic [7:0]      sel1_r, sel2_r;
    logic [AWID-1:0] adr1_r, adr2_r;
    logic [63:0]     dat1_r, dat2_r;
    logic [63:0]     lo, hi;
    logic [7:0]      tmo_cnt;

    logic            in_acc, tmo_hit;
    logic [3:0]      c_n;
    logic [15:0]     c_mask;
    logic [63:0]     c_bytes;
    logic [127:0]    c_wdat;
    logic [63:0]     rd_sh, rd_ext;

    // Lane and data placement for the request on the input, used only at capture.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        c_n     = 4'd1 << req_size;
        c_mask  = ((16'd1 << c_n) - 16'd1) << req_ea[2:0];
        c_bytes = req_dat;
        case (req_size)
            2'd0:    c_bytes = {56'd0, req_dat[7:0]};
            2'd1:    c_bytes = {48'd0, req_dat[15:0]};
            2'd2:    c_bytes = {32'd0, req_dat[31:0]};
            default: c_bytes = req_dat;
        endcase
        c_wdat = {64'd0, c_bytes} << {req_ea[2:0], 3'b000};
    end

    assign in_acc  = (state == ACC1) || (state == ACC2);
    assign tmo_hit = in_acc && !bus.ack_i && !bus.err_i && (tmo_cnt == 8'(TMO - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (req_valid) state_d = ACC1;
            ACC1: begin
                if (bus.err_i || tmo_hit) state_d = RESP;
                else if (bus.ack_i)       state_d = split_r ? ACC2 : RESP;
            end
            ACC2: if (bus.err_i || bus.ack_i || tmo_hit) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_r    <= 1'b0;
            sext_r  <= 1'b0;
            split_r <= 1'b0;
            err_r   <= 1'b0;
            size_r  <= '0;
            off_r   <= '0;
            sel1_r  <= '0;
            sel2_r  <= '0;
            adr1_r  <= '0;
            adr2_r  <= '0;
            dat1_r  <= '0;
            dat2_r  <= '0;
            lo      <= '0;
            hi      <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_r    <= req_we;
                    sext_r  <= req_sext;
                    size_r  <= req_size;
                    off_r   <= req_ea[2:0];
                    sel1_r  <= c_mask[7:0];
                    sel2_r  <= c_mask[15:8];
                    split_r <= (c_mask[15:8] != 8'd0);
                    adr1_r  <= {req_ea[AWID-1:3], 3'b000};
                    adr2_r  <= {req_ea[AWID-1:3], 3'b000} + AWID'(8);
                    dat1_r  <= c_wdat[63:0];
                    dat2_r  <= c_wdat[127:64];
                    lo      <= '0;
                    hi      <= '0;
                    err_r   <= 1'b0;
                    tmo_cnt <= '0;
                end
                ACC1, ACC2: begin
                    // Error wins over a simultaneous ack; the second half is then skipped.
                    if (bus.err_i || tmo_hit) begin
                        err_r   <= 1'b1;
                        tmo_cnt <= '0;
                    end else if (bus.ack_i) begin
                        if (state == ACC1) lo <= bus.dat_i;
                        else               hi <= bus.dat_i;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        bus.cyc_o  = in_acc;
        bus.stb_o  = in_acc;
        bus.we_o   = in_acc && we_r;
        bus.sel_o  = '0;
        bus.adr_o  = '0;
        bus.dat_o  = '0;
        if (state == ACC1) begin
            bus.sel_o = sel1_r;
            bus.adr_o = adr1_r;
            bus.dat_o = dat1_r;
        end else if (state == ACC2) begin
            bus.sel_o = sel2_r;
            bus.adr_o = adr2_r;
            bus.dat_o = dat2_r;
        end
    end

    // Bytes of the access sit at {hi,lo}[off*8 +: n*8]; lanes outside are discarded.
    always_comb begin
        rd_sh = 64'({hi, lo} >> {off_r, 3'b000});
        case (size_r)
            2'd0:    rd_ext = {{56{sext_r & rd_sh[7]}},  rd_sh[7:0]};
            2'd1:    rd_ext = {{48{sext_r & rd_sh[15]}}, rd_sh[15:0]};
            2'd2:    rd_ext = {{32{sext_r & rd_sh[31]}}, rd_sh[31:0]};
            default: rd_ext = rd_sh;
        endcase
        resp_valid = (state == RESP);
        resp_err   = resp_valid && err_r;
        resp_dat   = (resp_valid && !we_r) ? rd_ext : 64'd0;
    end

endmodule
